// File: rtl/psa_sat_stage.sv
// psa_sat_stage: per-lane overflow detection and saturation for the 4x4-bit
// parallel sub-word adder. Results go through a 2-entry valid/ready queue
// toward writeback. The stage also keeps a sticky overflow-event counter and
// an adder-consistency flag.
module psa_sat_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [15:0]      in_sum,
    input  logic             in_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [3:0]       out_ovf,
    output logic [CNT_W-1:0] ovf_count,
    output logic             chk_err,
    input  logic             clr_status
);

    localparam int LANES = 4;

    typedef struct packed {
        logic [LANES-1:0] ovf;
        logic [15:0]      result;
    } entry_t;

    entry_t     in_entry;
    entry_t     head;
    entry_t     tail;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       any_ovf;

    // Saturate each lane independently; a lane overflows when both operands
    // share a sign that the wrapped sum does not.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        in_entry = '0;
        for (int i = 0; i < LANES; i++) begin
            in_entry.ovf[i] = (in_a[4*i+3] == in_b[4*i+3]) &&
                              (in_sum[4*i+3] != in_a[4*i+3]);
            if (in_entry.ovf[i]) begin
                in_entry.result[4*i +: 4] = in_a[4*i+3] ? 4'b1000 : 4'b0111;
            end else begin
                in_entry.result[4*i +: 4] = in_sum[4*i +: 4];
            end
        end
    end

    // in_ready comes only from the registered occupancy, so there is no
    // combinational path from out_ready back to upstream.
    assign in_ready   = (count != 2'd2);
    assign out_valid  = (count != 2'd0);
    assign out_result = head.result;
    assign out_ovf    = head.ovf;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign any_ovf    = |in_entry.ovf;

    // Two-entry FIFO: head feeds the output, tail holds the second entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage is reset as well as the count, because the
            // head is visible on out_result and must read zero after reset.
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples
            // pre-edge values no matter what order the statements run in.
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_entry;
                    else               tail <= in_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // With a single entry the head keeps its stale value.
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy stays the same; the new entry goes behind
                    // whatever remains after the pop.
                    if (count == 2'd1) begin
                        head <= in_entry;
                    end else begin
                        head <= tail;
                        tail <= in_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky status, updated on acceptance; clr_status wins over updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
            chk_err   <= 1'b0;
        end else if (clr_status) begin
            ovf_count <= '0;
            chk_err   <= 1'b0;
        end else if (push) begin
            if (any_ovf && (ovf_count != {CNT_W{1'b1}})) begin
                ovf_count <= ovf_count + 1'b1;
            end
            if (in_err != any_ovf) begin
                chk_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psa_sat_stage.sv
// Self-checking bench for psa_sat_stage. The reference model computes each
// lane as a saturating signed add and tracks a FIFO of expected entries.
module tb_psa_sat_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] in_sum;
    logic        in_err;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_ovf;
    logic [7:0]  ovf_count;
    logic        chk_err;
    logic        clr_status;

    int total = 0;
    int bad   = 0;

    // Reference state: expected entries {ovf, result}, and the status values.
    logic [19:0] q[$];
    logic [7:0]  m_cnt;
    logic        m_chk;

    psa_sat_stage #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_err(in_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf),
        .ovf_count(ovf_count), .chk_err(chk_err), .clr_status(clr_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Saturating signed 4-bit add per lane, returned as {ovf mask, result}.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  m;
        int sa;
        int sb;
        int t;
        r = '0;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            sa = int'($signed(a[4*i +: 4]));
            sb = int'($signed(b[4*i +: 4]));
            t  = sa + sb;
            if (t > 7) begin
                t = 7;
                m[i] = 1'b1;
            end else if (t < -8) begin
                t = -8;
                m[i] = 1'b1;
            end
            r[4*i +: 4] = t[3:0];
        end
        return {m, r};
    endfunction

    // Wrapped lane-wise sum, as the upstream adder would produce it.
    function automatic logic [15:0] wsum(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = a[4*i +: 4] + b[4*i +: 4];
        return r;
    endfunction

    // Drive one cycle of stimulus (called at posedge+1) and advance the model.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] s, input logic e, input logic ordy,
                        input logic clr, output logic acc);
        logic        pop;
        logic [19:0] ent;
        logic [19:0] gone;
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        in_sum     = s;
        in_err     = e;
        out_ready  = ordy;
        clr_status = clr;
        acc = v && (q.size() < 2);
        pop = ordy && (q.size() > 0);
        ent = model(a, b);
        @(posedge clk);
        if (pop) gone = q.pop_front();
        if (acc) q.push_back(ent);
        if (clr) begin
            m_cnt = 8'h00;
            m_chk = 1'b0;
        end else if (acc) begin
            if (ent[19:16] != 4'h0 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
            if (e != (ent[19:16] != 4'h0)) m_chk = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 0; in_a = 0; in_b = 0; in_sum = 0; in_err = 0;
        out_ready = 0; clr_status = 0;
        q.delete();
        m_cnt = 0;
        m_chk = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_result !== 16'h0) begin bad++; $display("FAIL reset_out_result got=%h want=0000", out_result); end
        total++; if (out_ovf !== 4'h0) begin bad++; $display("FAIL reset_out_ovf got=%b want=0000", out_ovf); end
        total++; if (ovf_count !== 8'h0 || chk_err !== 1'b0) begin bad++; $display("FAIL reset_status got=%h/%b want=00/0", ovf_count, chk_err); end
        rst = 1'b0;
    endtask

    task automatic test_clean_add;
        logic acc;
        step(1, 16'h1234, 16'h2121, 16'h3355, 0, 1, 0, acc);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clean_valid got=%b want=1", out_valid); end
        total++; if (out_result !== 16'h3355 || out_ovf !== 4'b0000) begin bad++; $display("FAIL clean_data got=%h/%b want=3355/0000", out_result, out_ovf); end
        total++; if (ovf_count !== 8'd0) begin bad++; $display("FAIL clean_count got=%0d want=0", ovf_count); end
    endtask

    task automatic test_pos_sat;
        logic acc;
        // The previous entry pops in the same edge, so the head is replaced.
        step(1, 16'h7777, 16'h1111, 16'h8888, 1, 1, 0, acc);
        total++; if (out_result !== 16'h7777 || out_ovf !== 4'b1111) begin bad++; $display("FAIL pos_sat_data got=%h/%b want=7777/1111", out_result, out_ovf); end
        total++; if (ovf_count !== 8'd1 || chk_err !== 1'b0) begin bad++; $display("FAIL pos_sat_status got=%0d/%b want=1/0", ovf_count, chk_err); end
    endtask

    task automatic test_neg_sat;
        logic acc;
        step(1, 16'h8000, 16'hF000, 16'h7000, 1, 1, 0, acc);
        total++; if (out_result !== 16'h8000 || out_ovf !== 4'b1000) begin bad++; $display("FAIL neg_sat_data got=%h/%b want=8000/1000", out_result, out_ovf); end
        total++; if (ovf_count !== 8'd2 || chk_err !== 1'b0) begin bad++; $display("FAIL neg_sat_status got=%0d/%b want=2/0", ovf_count, chk_err); end
    endtask

    task automatic test_consistency;
        logic acc;
        step(1, 16'h1234, 16'h2121, 16'h3355, 1, 1, 0, acc);
        total++; if (chk_err !== 1'b1) begin bad++; $display("FAIL chk_set got=%b want=1", chk_err); end
        step(0, 0, 0, 0, 0, 1, 0, acc);
        total++; if (chk_err !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL chk_sticky got=%b/%b want=1/0", chk_err, out_valid); end
        // Clear coincides with an overflow accept: clear must win.
        step(1, 16'h7777, 16'h1111, 16'h8888, 1, 0, 1, acc);
        total++; if (ovf_count !== 8'd0 || chk_err !== 1'b0) begin bad++; $display("FAIL clr_priority got=%0d/%b want=0/0", ovf_count, chk_err); end
        step(0, 0, 0, 0, 0, 1, 0, acc);
    endtask

    task automatic test_backpressure;
        logic acc;
        step(1, 16'h1111, 16'h1111, 16'h2222, 0, 0, 0, acc);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b want=1", in_ready); end
        step(1, 16'h7000, 16'h7000, 16'hE000, 1, 0, 0, acc);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", in_ready); end
        step(1, 16'h0123, 16'h0F0F, 16'h0022, 0, 0, 0, acc);
        total++; if (in_ready !== 1'b0 || out_result !== 16'h2222) begin bad++; $display("FAIL bp_hold got=%b/%h want=0/2222", in_ready, out_result); end
        step(1, 16'h0123, 16'h0F0F, 16'h0022, 0, 1, 0, acc);
        total++; if (out_valid !== 1'b1 || out_result !== 16'h7000 || out_ovf !== 4'b1000) begin bad++; $display("FAIL bp_pop2 got=%b/%h/%b want=1/7000/1000", out_valid, out_result, out_ovf); end
        step(1, 16'h0123, 16'h0F0F, 16'h0022, 0, 1, 0, acc);
        total++; if (out_valid !== 1'b1 || out_result !== 16'h0022 || out_ovf !== 4'b0000) begin bad++; $display("FAIL bp_pop3 got=%b/%h/%b want=1/0022/0000", out_valid, out_result, out_ovf); end
        step(0, 0, 0, 0, 0, 1, 0, acc);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        logic acc;
        step(1, 16'h7777, 16'h1111, 16'h8888, 1, 0, 0, acc);
        step(1, 16'h1234, 16'h2121, 16'h3355, 1, 0, 0, acc);
        in_valid = 0;
        #1 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_flow got=%b/%b want=0/1", out_valid, in_ready); end
        total++; if (ovf_count !== 8'd0 || chk_err !== 1'b0) begin bad++; $display("FAIL mid_rst_status got=%0d/%b want=0/0", ovf_count, chk_err); end
        #1 rst = 1'b0;
        q.delete();
        m_cnt = 0;
        m_chk = 0;
        @(posedge clk);
        #1;
        step(1, 16'h1234, 16'h2121, 16'h3355, 0, 0, 0, acc);
        total++; if (out_valid !== 1'b1 || out_result !== 16'h3355 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_first got=%b/%h/%b want=1/3355/1", out_valid, out_result, in_ready); end
        step(0, 0, 0, 0, 0, 1, 0, acc);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_alone got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic        acc;
        logic [15:0] a;
        logic [15:0] b;
        logic [19:0] exp;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            exp = model(a, b);
            step(1, a, b, wsum(a, b), |exp[19:16], 1, 0, acc);
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || {out_ovf, out_result} !== exp) begin
                bad++;
                $display("FAIL b2b_%0d got=%b/%b/%h want=1/1/%h", i, in_ready, out_valid, {out_ovf, out_result}, exp);
            end
        end
        step(0, 0, 0, 0, 0, 1, 0, acc);
    endtask

    task automatic test_counter_sat;
        logic acc;
        step(0, 0, 0, 0, 0, 1, 1, acc);
        for (int i = 1; i <= 256; i++) begin
            step(1, 16'h7777, 16'h1111, 16'h8888, 1, 1, 0, acc);
            if (i == 128) begin
                total++; if (ovf_count !== 8'd128) begin bad++; $display("FAIL cnt_mid got=%0d want=128", ovf_count); end
            end
        end
        total++; if (ovf_count !== 8'd255) begin bad++; $display("FAIL cnt_sat got=%0d want=255", ovf_count); end
        step(0, 0, 0, 0, 0, 1, 1, acc);
    endtask

    task automatic test_random;
        logic        acc;
        logic [15:0] a;
        logic [15:0] b;
        logic [19:0] exp;
        logic        e;
        for (int i = 0; i < 500; i++) begin
            total++;
            if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready_%0d got=%b want=%b", i, in_ready, q.size() < 2); end
            a = 16'($urandom);
            b = 16'($urandom);
            exp = model(a, b);
            e = (|exp[19:16]) ^ ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 3) != 0, a, b, wsum(a, b), e,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, acc);
            total++;
            if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid_%0d got=%b want=%b", i, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                total++;
                if ({out_ovf, out_result} !== q[0]) begin bad++; $display("FAIL rnd_head_%0d got=%h want=%h", i, {out_ovf, out_result}, q[0]); end
            end
            total++;
            if (ovf_count !== m_cnt || chk_err !== m_chk) begin bad++; $display("FAIL rnd_status_%0d got=%0d/%b want=%0d/%b", i, ovf_count, chk_err, m_cnt, m_chk); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_add();
        test_pos_sat();
        test_neg_sat();
        test_consistency();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_counter_sat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
